inv_pipeline: RTL and testbench
===============================

Name: inv_pipeline

Overview:
- Parametrised, clocked successor to the team's single-bit static CMOS inverter.
- Moves WIDTH-bit words through DEPTH elastic register stages; each stage conditionally inverts its word.
- Valid/ready handshake on both sides; full backpressure, flush and occupancy reporting.
- Sits between datapath blocks as a polarity-correcting, latency-matching buffer.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- INV_MASK, {DEPTH{1'b1}}, bit k=1: stage k inverts words whose inv tag is set (stage 0 = ingress side).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  WIDTH  ingress word.
- in_inv  input  1  inversion tag; travels with the word.
- in_valid  input  1  ingress word present.
- in_ready  output  1  pipeline accepts the ingress word this cycle.
- out_data  output  WIDTH  egress word (stage DEPTH-1 register).
- out_inv  output  1  tag of the egress word.
- out_valid  output  1  egress word present.
- out_ready  input  1  downstream accepts the egress word.
- flush  input  1  synchronous discard of all contents.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge.
- Reset: all stage valids=0, data=0, tags=0, occupancy=0. Consequently out_valid=0, out_data=0, out_inv=0, and in_ready=1 from the first cycle after reset releases.
- Stage k holds {valid_k, tag_k, data_k}.
- Advance rule: go_{DEPTH-1} = !valid_{DEPTH-1} | out_ready. For k<DEPTH-1: go_k = !valid_k | go_{k+1}. This is combinational and ripples from the egress side.
- in_ready = go_0 & !flush. Ingress transfer occurs when in_valid & in_ready.
- On go_k, stage k loads from stage k-1 (stage 0 loads from the ingress ports):
  - valid <= upstream valid (ingress transfer for stage 0);
  - tag <= upstream tag;
  - data <= upstream data XOR {WIDTH{INV_MASK[k] & upstream tag}}.
- When !go_k, stage k holds its value.
- Net function: out_data = in_data XOR {WIDTH{in_inv & ^INV_MASK}}; out_inv = in_inv.
- Latency is exactly DEPTH cycles with no stall: a word accepted at edge n gives out_valid=1 after edge n+DEPTH-1.
- Throughput is one word per cycle with out_ready held 1.
- Egress transfer: out_valid & out_ready.
- Full (occupancy==DEPTH) with out_ready=0: in_ready=0 and all stages hold.
- Full with out_ready=1 and in_valid=1: egress and ingress complete in the same cycle; occupancy stays DEPTH.
- Bubbles collapse: a stage with valid=0 always accepts, even while downstream is stalled.
- Empty: out_valid=0, out_data holds its last value (not required to be zero).
- occupancy = popcount of stage valids, registered and updated at the same edge as the valids.
- flush=1: in_ready=0; at the edge all valids clear and occupancy goes to 0. Data and tags hold. Any in_valid that cycle is dropped.
- flush and rst_n low together: reset wins; the result is identical anyway.
- Reset mid-stream: all in-flight words are discarded with no partial output. out_valid drops at the reset edge.
- Handshake rules on both interfaces:
  - A producer holds data and tag stable while valid=1 and ready=0.
  - The block never drops out_valid without a transfer, except on flush or reset.

Test Plan:
- Reset, then DEPTH=4, INV_MASK=4'b0001, in_data=8'hA5, in_inv=1, out_ready=1 -> out_valid=1 four cycles later, out_data=8'h5A, out_inv=1, occupancy=1 during transit.
- Same config, INV_MASK=4'b0011, in_inv=1, word 8'h3C -> out_data=8'h3C (even parity). Repeat with in_inv=0 -> 8'h3C.
- Stream 8'h00..8'h09 back-to-back with out_ready=1 -> ten consecutive out_valid cycles, in order, correct inversion, in_ready constantly 1.
- Hold out_ready=0 while feeding 6 words -> after 4 accepted, in_ready=0 and occupancy=4. Raise out_ready for 1 cycle with in_valid=1 -> one egress plus one ingress, occupancy stays 4, order preserved.
- Fill 3 words, assert flush for 1 cycle with in_valid=1 -> in_ready=0 that cycle, occupancy=0 next cycle, out_valid=0, and the dropped word never appears.
- Drive rst_n=0 for one edge while 4 words are in flight -> out_valid=0, occupancy=0, out_data=0 next cycle. The pipeline then accepts fresh words normally.

Source files
------------

// File: rtl/inv_pipeline.sv
// Elastic DEPTH-stage register pipeline that carries an inversion tag with each word.
// Each stage optionally inverts tagged words; valid/ready on both sides, flush, occupancy.
module inv_pipeline #(
    parameter int unsigned          WIDTH    = 8,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [DEPTH-1:0]     INV_MASK = {DEPTH{1'b1}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_inv,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_inv,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_tag;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [OCC_W-1:0] r_occ;

    logic [DEPTH-1:0] w_go;
    logic [DEPTH-1:0] w_up_valid;
    logic [DEPTH-1:0] w_up_tag;
    logic [WIDTH-1:0] w_up_data [DEPTH];
    logic [DEPTH-1:0] w_valid_nxt;
    logic [OCC_W-1:0] w_occ_nxt;
    logic             w_in_xfer;

    // A stage may advance when any stage at or beyond it is empty, or the egress drains.
    // Written as a flat reduction so there is no combinational self-dependency.
    for (genvar g = 0; g < DEPTH; g++) begin : g_go
        assign w_go[g] = out_ready | ~(&r_valid[DEPTH-1:g]);
    end

    assign in_ready  = w_go[0] & ~flush;
    assign w_in_xfer = in_valid & in_ready;

    always_comb begin
        w_up_valid[0] = w_in_xfer;
        w_up_tag[0]   = in_inv;
        w_up_data[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_up_valid[k] = r_valid[k-1];
            w_up_tag[k]   = r_tag[k-1];
            w_up_data[k]  = r_data[k-1];
        end
    end

    always_comb begin
        w_valid_nxt = '0;
        w_occ_nxt   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush)
                w_valid_nxt[k] = 1'b0;
            else if (w_go[k])
                w_valid_nxt[k] = w_up_valid[k];
            else
                w_valid_nxt[k] = r_valid[k];
            w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[k]);
        end
    end

    // Flush only clears valids; payload registers keep their contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_tag   <= '0;
            r_occ   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_go[k] && !flush) begin
                    r_tag[k]  <= w_up_tag[k];
                    r_data[k] <= w_up_data[k] ^ {WIDTH{INV_MASK[k] & w_up_tag[k]}};
                end
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_inv   = r_tag[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_inv_pipeline.sv
// Bench for inv_pipeline: two instances (odd and even inversion parity) share stimulus;
// a queue of in-flight words with stage positions predicts every output.
module tb_inv_pipeline;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_inv;
    logic       in_valid;
    logic       out_ready;
    logic       flush;

    logic       in_ready1, out_inv1, out_valid1;
    logic [7:0] out_data1;
    logic [2:0] occ1;
    logic       in_ready2, out_inv2, out_valid2;
    logic [7:0] out_data2;
    logic [2:0] occ2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inv_pipeline #(.WIDTH(8), .DEPTH(DEPTH), .INV_MASK(4'b0001)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_inv(in_inv),
        .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1),
        .out_inv(out_inv1), .out_valid(out_valid1), .out_ready(out_ready),
        .flush(flush), .occupancy(occ1));

    inv_pipeline #(.WIDTH(8), .DEPTH(DEPTH), .INV_MASK(4'b0011)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_inv(in_inv),
        .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2),
        .out_inv(out_inv2), .out_valid(out_valid2), .out_ready(out_ready),
        .flush(flush), .occupancy(occ2));

    // Reference: each in-flight word with its current stage index.
    typedef struct {
        logic [7:0] d;
        logic       inv;
        int         pos;
    } wd_t;
    wd_t q[$];

    logic       exp_valid, exp_inv, exp_ready;
    logic [7:0] exp_data1, exp_data2;
    int         exp_occ;

    task automatic model_eval();
        exp_valid = (q.size() > 0) && (q[0].pos == DEPTH-1);
        exp_data1 = (q.size() > 0) ? (q[0].d ^ {8{q[0].inv}}) : 8'h00;
        exp_data2 = (q.size() > 0) ? q[0].d : 8'h00;
        exp_inv   = (q.size() > 0) ? q[0].inv : 1'b0;
        exp_occ   = q.size();
        exp_ready = !flush && ((q.size() < DEPTH) || out_ready);
    endtask

    task automatic model_edge();
        int  lim;
        wd_t w;
        if (!rst_n || flush) begin
            q.delete();
            return;
        end
        if (exp_valid && out_ready) void'(q.pop_front());
        lim = DEPTH-1;
        for (int i = 0; i < q.size(); i++) begin
            q[i].pos = (q[i].pos + 1 < lim) ? q[i].pos + 1 : lim;
            lim = q[i].pos - 1;
        end
        if (in_valid && exp_ready) begin
            w.d = in_data; w.inv = in_inv; w.pos = 0;
            q.push_back(w);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_inv = 1'b0;
        out_ready = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        sample();
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid1); end
        total++; if (out_data1 !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", out_data1); end
        total++; if (out_inv1 !== 1'b0) begin bad++; $display("FAIL rst_out_inv got=%b exp=0", out_inv1); end
        total++; if (occ1 !== 3'd0) begin bad++; $display("FAIL rst_occupancy got=%0d exp=0", occ1); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready1); end
        total++; if (out_valid2 !== 1'b0 || out_data2 !== 8'h00) begin
            bad++; $display("FAIL rst_dut2 got=%b/%h exp=0/00", out_valid2, out_data2); end
        tick();
    endtask

    task automatic test_latency(input logic [7:0] d, input logic inv,
                                input logic [7:0] e1, input logic [7:0] e2);
        out_ready = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_data = d; in_inv = inv;
        sample();
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL lat_in_ready got=%b exp=1", in_ready1); end
        tick();
        in_valid = 1'b0; in_data = 8'hFF;
        for (int c = 1; c <= 4; c++) begin
            sample();
            if (c < 4) begin
                total++; if (out_valid1 !== 1'b0 || occ1 !== 3'd1) begin
                    bad++; $display("FAIL lat_transit c=%0d valid=%b occ=%0d exp=0/1", c, out_valid1, occ1); end
            end else begin
                total++; if (out_valid1 !== 1'b1 || out_valid2 !== 1'b1) begin
                    bad++; $display("FAIL lat_arrive valid=%b/%b exp=1/1", out_valid1, out_valid2); end
                total++; if (out_data1 !== e1) begin bad++; $display("FAIL lat_data1 got=%h exp=%h", out_data1, e1); end
                total++; if (out_data2 !== e2) begin bad++; $display("FAIL lat_data2 got=%h exp=%h", out_data2, e2); end
                total++; if (out_inv1 !== inv) begin bad++; $display("FAIL lat_inv got=%b exp=%b", out_inv1, inv); end
            end
            tick();
        end
        sample();
        total++; if (out_valid1 !== 1'b0 || occ1 !== 3'd0) begin
            bad++; $display("FAIL lat_drained valid=%b occ=%0d exp=0/0", out_valid1, occ1); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n_out = 0;
        int first = -1;
        int last  = -1;
        logic [7:0] e;
        out_ready = 1'b1; flush = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 10);
            in_data  = 8'(c);
            in_inv   = c[0];
            sample();
            if (c < 10) begin
                total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready1); end
            end
            if (out_valid1 === 1'b1) begin
                e = 8'(n_out) ^ {8{n_out[0]}};
                total++; if (out_data1 !== e || out_inv1 !== n_out[0]) begin
                    bad++; $display("FAIL b2b_data n=%0d got=%h/%b exp=%h/%b", n_out, out_data1, out_inv1, e, n_out[0]); end
                if (first < 0) first = c;
                last = c;
                n_out++;
            end
            tick();
        end
        total++; if (n_out != 10 || last - first != 9) begin
            bad++; $display("FAIL b2b_count got=%0d span=%0d exp=10/9", n_out, last - first); end
    endtask

    task automatic test_backpressure();
        logic [7:0] w [6];
        int idx = 0;
        int got = 0;
        for (int i = 0; i < 6; i++) w[i] = 8'h10 + 8'(i);
        out_ready = 1'b0; flush = 1'b0; in_inv = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_data = w[idx];
            sample();
            tick();
            if (exp_ready) idx++;
        end
        sample();
        total++; if (idx != 4 || occ1 !== 3'd4 || in_ready1 !== 1'b0) begin
            bad++; $display("FAIL bp_full accepted=%0d occ=%0d in_ready=%b exp=4/4/0", idx, occ1, in_ready1); end
        tick();
        out_ready = 1'b1; in_data = w[idx];
        sample();
        total++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b1 || out_data1 !== ~w[0]) begin
            bad++; $display("FAIL bp_swap ready=%b valid=%b data=%h exp=1/1/%h", in_ready1, out_valid1, out_data1, ~w[0]); end
        tick();
        idx++;
        out_ready = 1'b0;
        sample();
        total++; if (occ1 !== 3'd4 || out_data1 !== ~w[1] || in_ready1 !== 1'b0) begin
            bad++; $display("FAIL bp_after occ=%0d data=%h ready=%b exp=4/%h/0", occ1, out_data1, in_ready1, ~w[1]); end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (out_valid1 === 1'b1) begin
                total++; if (got > 3 || out_data1 !== ~w[got + 1]) begin
                    bad++; $display("FAIL bp_order n=%0d got=%h", got, out_data1); end
                got++;
            end
            tick();
        end
        total++; if (got != 4) begin bad++; $display("FAIL bp_drain got=%0d exp=4", got); end
    endtask

    task automatic test_flush();
        int seen = 0;
        out_ready = 1'b0; flush = 1'b0; in_inv = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = 8'h40 + 8'(c);
            sample();
            tick();
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        sample();
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%b exp=0", in_ready1); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sample();
        total++; if (occ1 !== 3'd0 || out_valid1 !== 1'b0) begin
            bad++; $display("FAIL fl_cleared occ=%0d valid=%b exp=0/0", occ1, out_valid1); end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (out_valid1 === 1'b1) seen++;
            tick();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL fl_ghost got=%0d words exp=0", seen); end
    endtask

    task automatic test_reset_midstream();
        int wait_c = 0;
        out_ready = 1'b0; flush = 1'b0; in_inv = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_data = 8'h60 + 8'(c);
            sample();
            tick();
        end
        in_valid = 1'b0; rst_n = 1'b0;
        sample();
        tick();
        rst_n = 1'b1;
        sample();
        total++; if (out_valid1 !== 1'b0 || occ1 !== 3'd0 || out_data1 !== 8'h00 || out_inv1 !== 1'b0) begin
            bad++; $display("FAIL mid_rst valid=%b occ=%0d data=%h inv=%b exp=0/0/00/0", out_valid1, occ1, out_data1, out_inv1); end
        tick();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h77; in_inv = 1'b1;
        sample();
        tick();
        in_valid = 1'b0;
        sample();
        while (out_valid1 !== 1'b1 && wait_c < 8) begin
            tick();
            sample();
            wait_c++;
        end
        total++; if (out_valid1 !== 1'b1 || wait_c != 3 || out_data1 !== 8'h88) begin
            bad++; $display("FAIL mid_fresh valid=%b wait=%0d data=%h exp=1/3/88", out_valid1, wait_c, out_data1); end
        tick();
    endtask

    task automatic test_random();
        logic held = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!held) begin
                in_valid = ($urandom_range(9) < 7);
                in_data  = 8'($urandom);
                in_inv   = 1'($urandom);
            end
            out_ready = ($urandom_range(9) < 6);
            flush     = ($urandom_range(39) == 0);
            sample();
            total++; if (in_ready1 !== exp_ready || in_ready2 !== exp_ready) begin
                bad++; $display("FAIL rnd_in_ready c=%0d got=%b/%b exp=%b", c, in_ready1, in_ready2, exp_ready); end
            total++; if (out_valid1 !== exp_valid || out_valid2 !== exp_valid) begin
                bad++; $display("FAIL rnd_out_valid c=%0d got=%b/%b exp=%b", c, out_valid1, out_valid2, exp_valid); end
            total++; if (occ1 !== 3'(exp_occ) || occ2 !== 3'(exp_occ)) begin
                bad++; $display("FAIL rnd_occupancy c=%0d got=%0d/%0d exp=%0d", c, occ1, occ2, exp_occ); end
            if (exp_valid) begin
                total++; if (out_data1 !== exp_data1 || out_data2 !== exp_data2 || out_inv1 !== exp_inv || out_inv2 !== exp_inv) begin
                    bad++; $display("FAIL rnd_data c=%0d got=%h/%h/%b exp=%h/%h/%b", c, out_data1, out_data2, out_inv1, exp_data1, exp_data2, exp_inv); end
            end
            held = in_valid && !exp_ready;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency(8'hA5, 1'b1, 8'h5A, 8'hA5);
        test_latency(8'h3C, 1'b1, 8'hC3, 8'h3C);
        test_latency(8'h3C, 1'b0, 8'h3C, 8'h3C);
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1);
    end

endmodule
